bnn_param_loader: RTL and testbench
===================================

Name: bnn_param_loader

Overview:
- Upstream feeder for the 8-8-4 BNN core's parameter store (20 neurons, each with an 8-bit weight and a 4-bit threshold).
- Accepts a nibble-serial parameter stream from the bidirectional pins under a valid/ready handshake.
- Assembles one {weight, threshold} record per neuron and issues a single-cycle write into the store at an auto-incrementing address.
- Frames the whole load with start, busy and done status; an optional checksum nibble closes the frame.

Parameters:
- NUM_NEURONS, 20, number of records per frame (layer1 8 + layer2 8 + layer3 4).
- ADDR_W, 5, width of wr_addr; must satisfy 2^ADDR_W >= NUM_NEURONS.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- ena  in  1  global enable; when low, no handshake completes and the FSM holds
- start  in  1  single-cycle pulse; begins a new frame at address 0
- nib_valid  in  1  nib_data is valid
- nib_data  in  4  parameter nibble
- nib_ready  out  1  loader can accept a nibble this cycle
- wr_en  out  1  write strobe to the parameter store, one cycle per record
- wr_addr  out  ADDR_W  neuron index of the current write
- wr_weight  out  8  assembled weight
- wr_thresh  out  4  assembled threshold
- busy  out  1  frame in progress
- done  out  1  frame complete; held until the next start or reset
- err  out  1  checksum mismatch, sticky until the next start (0 when the feature is compiled out)

Behaviour:
- Clock and reset:
  - reset is asynchronous, active-high; clock is clk.
  - All outputs reset to 0; FSM resets to IDLE; address counter, nibble buffers and checksum accumulator reset to 0.
- Handshake:
  - A nibble is accepted when ena && nib_valid && nib_ready on a clk edge.
  - nib_ready is a registered FSM decode: high only in W_LO, W_HI, THR and CSUM, and only when ena=1.
- Record order: weight[3:0] first, then weight[7:4], then threshold[3:0]. Bit i of weight pairs with core input bit i.
- FSM states:
  - IDLE: start -> W_LO, with addr=0, done=0, err=0, csum=0, busy=1.
  - W_LO: accept -> buffer low nibble -> W_HI.
  - W_HI: accept -> buffer high nibble -> THR.
  - THR: accept -> latch threshold -> WRITE.
  - WRITE (1 cycle, nib_ready=0):
    - wr_en=1, with wr_addr/wr_weight/wr_thresh stable for that cycle.
    - If addr==NUM_NEURONS-1 -> CSUM (feature on) or DONE (feature off).
    - Otherwise addr+1 -> W_LO.
  - CSUM: accept -> compare -> DONE.
  - DONE: busy=0, done=1. start -> W_LO (as from IDLE).
- Latency and throughput:
  - wr_en asserts on the cycle after the threshold nibble is accepted.
  - Maximum throughput is 4 cycles per record.
- wr_weight/wr_thresh hold their last value when wr_en=0. The store must ignore them then.
- ena low mid-record: state, buffers and addr are all held. No timeout.
- start while busy: aborts the frame and restarts at W_LO/addr 0; the partially assembled record is discarded.
  - start coincident with a WRITE cycle: the write still completes, then restarts.
- reset mid-frame: immediate return to IDLE; no further writes. The store keeps whatever was already written.
- Address never wraps: no writes beyond NUM_NEURONS-1.
- Extra nibbles after DONE: not accepted (nib_ready=0).

Optional Feature:
- Macro: BNN_LOADER_CHECKSUM_EN.
- Defined:
  - csum is the 4-bit XOR of all 3*NUM_NEURONS data nibbles.
  - CSUM state accepts one trailing check nibble.
  - Mismatch sets err=1 at the same edge done rises; done still asserts.
  - Writes are not suppressed, since they were already committed.
- Undefined:
  - No CSUM state; WRITE of the last record goes directly to DONE.
  - err is tied to 0; frame is 3*NUM_NEURONS nibbles.

Decomposition:
- Shared package bnn_pkg holds:
  - NUM_NEURONS=20, L1_NEURONS=8, L2_NEURONS=8, L3_NEURONS=4;
  - WEIGHT_W=8, THRESH_W=4, NIB_W=4;
  - the loader FSM state enum.
- The top-level BNN core and this block share it.
- No sub-module: the nibble assembler and FSM are a single always block plus decode. Packing the record into one struct in bnn_pkg is optional.

Test Plan:
- Reset, then start, then 60 nibbles with valid held high → 20 wr_en pulses, each 4 cycles apart. Record 0 sequence 0xF,0xF,0x0 → addr 0, weight 0xFF, thresh 0x0. Record 19 sequence 0x3,0xC,0x4 → addr 19, weight 0xC3, thresh 0x4. done=1 and busy=0 after the last write.
- Random nib_valid gaps plus ena low for 5 cycles inside record 7 → same write data as the gap-free run; no write while ena=0.
- start pulsed after 2 nibbles of record 5 → no write for addr 5 from the old frame; next write is addr 0 with the new data.
- reset asserted during W_HI of record 3 → all outputs 0 at once; no wr_en until a new start.
- BNN_LOADER_CHECKSUM_EN: correct XOR nibble → done=1, err=0. Check nibble XOR 0x1 → done=1, err=1; a following start clears err.
- After done, hold nib_valid=1 for 10 cycles → nib_ready=0 and no wr_en.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared definitions for the 8-8-4 BNN core and its parameter loader.
package bnn_pkg;

    localparam int NUM_NEURONS = 20;
    localparam int L1_NEURONS  = 8;
    localparam int L2_NEURONS  = 8;
    localparam int L3_NEURONS  = 4;

    localparam int WEIGHT_W = 8;
    localparam int THRESH_W = 4;
    localparam int NIB_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_W_LO  = 3'd1,
        ST_W_HI  = 3'd2,
        ST_THR   = 3'd3,
        ST_WRITE = 3'd4,
        ST_CSUM  = 3'd5,
        ST_DONE  = 3'd6
    } loader_state_t;

endpackage

// File: rtl/bnn_param_loader.sv
// Nibble-serial loader for the BNN parameter store: assembles {weight, threshold}
// records and writes them at auto-incrementing addresses. Define BNN_LOADER_CHECKSUM_EN
// to require a trailing XOR check nibble per frame.
module bnn_param_loader #(
    parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
    parameter int ADDR_W      = 5
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ena,
    input  logic                          start,
    input  logic                          nib_valid,
    input  logic [bnn_pkg::NIB_W-1:0]     nib_data,
    output logic                          nib_ready,
    output logic                          wr_en,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [bnn_pkg::WEIGHT_W-1:0]  wr_weight,
    output logic [bnn_pkg::THRESH_W-1:0]  wr_thresh,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);
    import bnn_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NEURONS - 1);
`ifdef BNN_LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_LAST = ST_CSUM;
`else
    localparam loader_state_t AFTER_LAST = ST_DONE;
`endif

    loader_state_t           state_reg, state_next;
    logic [ADDR_W-1:0]       addr_reg;
    logic [NIB_W-1:0]        lo_reg, hi_reg;
    logic [WEIGHT_W-1:0]     weight_reg;
    logic [THRESH_W-1:0]     thresh_reg;
    logic                    restart, accept;

    // ena gates everything, including start, so a disabled loader is fully frozen
    assign restart = ena && start;
    assign accept  = ena && nib_valid && nib_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (restart) begin
            state_next = ST_W_LO;
        end else begin
            case (state_reg)
                ST_W_LO:  if (accept) state_next = ST_W_HI;
                ST_W_HI:  if (accept) state_next = ST_THR;
                ST_THR:   if (accept) state_next = ST_WRITE;
                ST_WRITE: if (ena) state_next = (addr_reg == LAST_ADDR) ? AFTER_LAST : ST_W_LO;
                ST_CSUM:  if (accept) state_next = ST_DONE;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_comb begin
        nib_ready = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_reg)
            ST_W_LO, ST_W_HI, ST_THR, ST_CSUM: begin
                nib_ready = ena;
                busy      = 1'b1;
            end
            ST_WRITE: begin
                wr_en = ena;
                busy  = 1'b1;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

`ifdef BNN_LOADER_CHECKSUM_EN
    logic [NIB_W-1:0] csum_reg;
    logic             err_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_reg <= '0;
            err_reg  <= 1'b0;
        end else if (restart) begin
            csum_reg <= '0;
            err_reg  <= 1'b0;
        end else if (accept) begin
            if (state_reg == ST_CSUM) begin
                if (nib_data != csum_reg) err_reg <= 1'b1;
            end else begin
                csum_reg <= csum_reg ^ nib_data;
            end
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    // Write outputs are only reloaded when a full record has been assembled,
    // so they stay stable across the gap between writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_reg   <= '0;
            lo_reg     <= '0;
            hi_reg     <= '0;
            weight_reg <= '0;
            thresh_reg <= '0;
        end else if (restart) begin
            addr_reg <= '0;
        end else begin
            case (state_reg)
                ST_W_LO: if (accept) lo_reg <= nib_data;
                ST_W_HI: if (accept) hi_reg <= nib_data;
                ST_THR: begin
                    if (accept) begin
                        weight_reg <= {hi_reg, lo_reg};
                        thresh_reg <= nib_data;
                    end
                end
                ST_WRITE: begin
                    if (ena && addr_reg != LAST_ADDR) addr_reg <= addr_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign wr_addr   = addr_reg;
    assign wr_weight = weight_reg;
    assign wr_thresh = thresh_reg;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Randomized directed bench for bnn_param_loader with a record-level reference model.
module tb_bnn_param_loader;

    localparam int N      = 20;
    localparam int NNIB   = 3 * N;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic       start;
    logic       nib_valid;
    logic [3:0] nib_data;
    logic       nib_ready;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_weight;
    logic [3:0] wr_thresh;
    logic       busy;
    logic       done;
    logic       err;

    bnn_param_loader #(.NUM_NEURONS(N), .ADDR_W(5)) dut (
        .clk(clk), .reset(reset), .ena(ena), .start(start),
        .nib_valid(nib_valid), .nib_data(nib_data), .nib_ready(nib_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_weight(wr_weight), .wr_thresh(wr_thresh),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int weight;
        int thresh;
        int cyc;
    } wr_t;

    wr_t        wr_q[$];
    wr_t        exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         pass_cnt = 0;
    logic [3:0] frame[NNIB];
    logic [3:0] frame0[NNIB];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wr_q.push_back('{int'(wr_addr), int'(wr_weight), int'(wr_thresh), cyc});
            $display("write addr=%0d weight=0x%02h thresh=0x%0h cyc=%0d", wr_addr, wr_weight, wr_thresh, cyc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_nib(input logic [3:0] d);
        nib_valid = 1'b1;
        nib_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (nib_ready === 1'b1 && ena === 1'b1) begin
                tick();
                nib_valid = 1'b0;
                return;
            end
        end
        check("nib_accept_timeout", 32'd0, 32'd1);
        nib_valid = 1'b0;
    endtask

    task automatic send_records(input int first, input int last, input bit gaps, input int glitch_idx);
        for (int i = 3 * first; i < 3 * last + 3; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            if (i == glitch_idx) begin
                nib_valid = 1'b1;
                nib_data  = frame[i];
                ena       = 1'b0;
                repeat (5) tick();
                ena = 1'b1;
            end
            send_nib(frame[i]);
        end
    endtask

    // Reference: record r is weight {n[3r+1], n[3r]}, threshold n[3r+2].
    task automatic expect_records(input int first, input int last);
        for (int r = first; r <= last; r++)
            exp_q.push_back('{r, int'({frame[3*r+1], frame[3*r]}), int'(frame[3*r+2]), 0});
    endtask

    function automatic logic [3:0] frame_xor();
        logic [3:0] x = 4'h0;
        for (int i = 0; i < NNIB; i++) x ^= frame[i];
        return x;
    endfunction

    task automatic randomize_frame();
        for (int i = 0; i < NNIB; i++) frame[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic send_check(input logic [3:0] flip);
`ifdef BNN_LOADER_CHECKSUM_EN
        send_nib(frame_xor() ^ flip);
`else
        if (flip != 4'h0) tick();
`endif
    endtask

    task automatic wait_done();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        tick();
    endtask

    task automatic compare_writes(input string tag, input bit spacing);
        int n;
        check($sformatf("%s_count", tag), wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, exp_q[i].addr);
            check($sformatf("%s_weight%0d", tag, i), wr_q[i].weight, exp_q[i].weight);
            check($sformatf("%s_thresh%0d", tag, i), wr_q[i].thresh, exp_q[i].thresh);
            if (spacing && i > 0)
                check($sformatf("%s_gap%0d", tag, i), wr_q[i].cyc - wr_q[i-1].cyc, 4);
        end
        wr_q.delete();
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1; ena = 1'b1; start = 1'b0; nib_valid = 1'b0; nib_data = 4'h0;
        repeat (3) tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_weight", wr_weight, 0);
        check("rst_wr_thresh", wr_thresh, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_nib_ready", nib_ready, 0);
        reset = 1'b0;
        tick();

        // Gap-free frame with fixed first and last records
        randomize_frame();
        frame[0] = 4'hF; frame[1] = 4'hF; frame[2] = 4'h0;
        frame[57] = 4'h3; frame[58] = 4'hC; frame[59] = 4'h4;
        frame0 = frame;
        pulse_start();
        check("start_busy", busy, 1);
        expect_records(0, N - 1);
        send_records(0, N - 1, 1'b0, -1);
        send_check(4'h0);
        wait_done();
        check("gapfree_done", done, 1);
        check("gapfree_busy", busy, 0);
        check("gapfree_err", err, 0);
        compare_writes("gapfree", 1'b1);

        // Extra nibbles after done are refused
        nib_valid = 1'b1;
        nib_data  = 4'h5;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("post_done_ready", nib_ready, 0);
            check("post_done_wr_en", wr_en, 0);
        end
        tick();
        nib_valid = 1'b0;
        check("post_done_writes", wr_q.size(), 0);

        // Same data with random valid gaps and ena low inside record 7
        frame = frame0;
        pulse_start();
        expect_records(0, N - 1);
        send_records(0, N - 1, 1'b1, 22);
        send_check(4'h0);
        wait_done();
        check("gaps_done", done, 1);
        compare_writes("gaps", 1'b0);

        // Abort after two nibbles of record 5
        randomize_frame();
        pulse_start();
        expect_records(0, 4);
        send_records(0, 4, 1'b0, -1);
        send_nib(frame[15]);
        send_nib(frame[16]);
        randomize_frame();
        pulse_start();
        expect_records(0, N - 1);
        send_records(0, N - 1, 1'b1, -1);
        send_check(4'h0);
        wait_done();
        check("abort_done", done, 1);
        compare_writes("abort", 1'b0);

        // Reset during W_HI of record 3
        randomize_frame();
        pulse_start();
        expect_records(0, 2);
        send_records(0, 2, 1'b0, -1);
        send_nib(frame[9]);
        reset = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", nib_ready, 0);
        check("midrst_wr_en", wr_en, 0);
        check("midrst_addr", wr_addr, 0);
        check("midrst_weight", wr_weight, 0);
        check("midrst_thresh", wr_thresh, 0);
        check("midrst_done", done, 0);
        tick();
        reset = 1'b0;
        nib_valid = 1'b1;
        repeat (8) tick();
        nib_valid = 1'b0;
        check("midrst_idle_ready", nib_ready, 0);
        compare_writes("midrst", 1'b0);

`ifdef BNN_LOADER_CHECKSUM_EN
        // Corrupted check nibble flags err; next start clears it
        randomize_frame();
        pulse_start();
        expect_records(0, N - 1);
        send_records(0, N - 1, 1'b0, -1);
        send_check(4'h1);
        wait_done();
        check("badsum_done", done, 1);
        check("badsum_err", err, 1);
        compare_writes("badsum", 1'b0);
        pulse_start();
        check("restart_err", err, 0);
        check("restart_done", done, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, checks);
        $finish;
    end

endmodule
